// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with bounded memory-ready wait and illegal-opcode trap.
// Optional `define CTRL_JUMP_EN adds the J (000010) instruction via state JUMP.
module multicycle_control_unit #(
  parameter int unsigned ALUC_W       = 4,
  parameter int unsigned MEM_WAIT_MAX = 16,
  parameter int unsigned CNT_W        = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [5:0]        opCode,
  input  logic [5:0]        func,
  input  logic              mem_ready,
  output logic              PCWrite,
  output logic              PCWriteCond,
  output logic              IorD,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              IRWrite,
  output logic              MemtoReg,
  output logic              RegDest,
  output logic              RegWrite,
  output logic              ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        PCSource,
  output logic              imm_zext,
  output logic              mem_half,
  output logic [ALUC_W-1:0] aluc,
  output logic              illegal,
  output logic              timeout,
  output logic [3:0]        state
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_I_EXEC   = 4'd10;
  localparam logic [3:0] S_I_WB     = 4'd11;
`ifdef CTRL_JUMP_EN
  localparam logic [3:0] S_JUMP     = 4'd12;
  localparam logic [5:0] OP_J       = 6'b000010;
`endif
  localparam logic [3:0] S_TRAP     = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  logic [3:0]       r_state;
  logic [3:0]       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_wait_state;
  logic             w_timeout_hit;
  logic             w_r_legal;
  logic [3:0]       w_r_aluc;
  logic [3:0]       w_i_aluc;
  logic             w_i_zext;
  logic             w_is_lh;

  assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_is_lh      = (opCode == OP_LH);

  generate
    if (MEM_WAIT_MAX != 0) begin : g_timeout
      assign w_timeout_hit = w_wait_state && !mem_ready &&
                             (r_cnt == CNT_W'(MEM_WAIT_MAX - 1));
    end else begin : g_no_timeout
      assign w_timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    w_r_legal = 1'b1;
    w_r_aluc  = ALU_ADD;
    case (func)
      FN_ADD:  w_r_aluc = ALU_ADD;
      FN_SUB:  w_r_aluc = ALU_SUB;
      FN_SLL:  w_r_aluc = ALU_SLL;
      FN_SRL:  w_r_aluc = ALU_SRL;
      FN_AND:  w_r_aluc = ALU_AND;
      FN_OR:   w_r_aluc = ALU_OR;
      FN_SLT:  w_r_aluc = ALU_SLT;
      default: w_r_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_i_aluc = ALU_ADD;
    w_i_zext = 1'b0;
    case (opCode)
      OP_ANDI: begin w_i_aluc = ALU_AND; w_i_zext = 1'b1; end
      OP_ORI:  begin w_i_aluc = ALU_OR;  w_i_zext = 1'b1; end
      default: w_i_aluc = ALU_ADD;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  w_state_next = S_FETCH;
      S_FETCH: if (mem_ready) w_state_next = S_DECODE;
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:               w_state_next = w_r_legal ? S_R_EXEC : S_TRAP;
          OP_LW, OP_LH, OP_SW:    w_state_next = S_MEM_ADDR;
          OP_BEQ:                 w_state_next = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI: w_state_next = S_I_EXEC;
`ifdef CTRL_JUMP_EN
          OP_J:                   w_state_next = S_JUMP;
`endif
          default:                w_state_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: w_state_next = (opCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready) w_state_next = S_MEM_WB;
      S_MEM_WB:   w_state_next = S_FETCH;
      S_MEM_WR:   if (mem_ready) w_state_next = S_FETCH;
      S_R_EXEC:   w_state_next = S_R_WB;
      S_R_WB:     w_state_next = S_FETCH;
      S_BRANCH:   w_state_next = S_FETCH;
      S_I_EXEC:   w_state_next = S_I_WB;
      S_I_WB:     w_state_next = S_FETCH;
`ifdef CTRL_JUMP_EN
      S_JUMP:     w_state_next = S_FETCH;
`endif
      S_TRAP:     w_state_next = S_TRAP;
      default:    w_state_next = S_TRAP;
    endcase
    if (w_timeout_hit) w_state_next = S_TRAP;
  end

  // In TRAP a nonzero count marks a timeout trap; decode traps enter with count 0.
  always_comb begin
    w_cnt_next = '0;
    if (r_state == S_TRAP) begin
      w_cnt_next = r_cnt;
    end else if (w_timeout_hit) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end else if (w_wait_state && (w_state_next == r_state)) begin
      w_cnt_next = r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDest     = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    PCSource    = 2'b00;
    imm_zext    = 1'b0;
    mem_half    = 1'b0;
    aluc        = '0;
    illegal     = 1'b0;
    timeout     = 1'b0;
    case (r_state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        aluc    = ALUC_W'(ALU_ADD);
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        aluc    = ALUC_W'(ALU_ADD);
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        aluc    = ALUC_W'(ALU_ADD);
      end
      S_MEM_RD: begin
        MemRead  = 1'b1;
        IorD     = 1'b1;
        mem_half = w_is_lh;
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        mem_half = w_is_lh;
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EXEC: begin
        ALUSrcA = 1'b1;
        aluc    = ALUC_W'(w_r_aluc);
      end
      S_R_WB: begin
        RegDest  = 1'b1;
        RegWrite = 1'b1;
        aluc     = ALUC_W'(w_r_aluc);
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        aluc        = ALUC_W'(ALU_SUB);
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_I_EXEC: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        aluc     = ALUC_W'(w_i_aluc);
        imm_zext = w_i_zext;
      end
      S_I_WB: begin
        RegWrite = 1'b1;
        aluc     = ALUC_W'(w_i_aluc);
        imm_zext = w_i_zext;
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
`endif
      S_TRAP: begin
        illegal = (r_cnt == '0);
        timeout = (r_cnt != '0);
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed self-checking bench for multicycle_control_unit; each task checks one scenario.
module tb_multicycle_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opCode;
  logic [5:0] func;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDest, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, PCSource;
  logic       imm_zext, mem_half, illegal, timeout;
  logic [3:0] aluc;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_control_unit #(
    .ALUC_W       (4),
    .MEM_WAIT_MAX (16),
    .CNT_W        (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .opCode      (opCode),
    .func        (func),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDest     (RegDest),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .PCSource    (PCSource),
    .imm_zext    (imm_zext),
    .mem_half    (mem_half),
    .aluc        (aluc),
    .illegal     (illegal),
    .timeout     (timeout),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Observed {state, all control outputs}
  wire [25:0] obs = {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                     RegDest, RegWrite, ALUSrcA, ALUSrcB, PCSource, imm_zext, mem_half, aluc,
                     illegal, timeout};

  function automatic logic [25:0] pk(input logic [3:0] st, input logic pcw, input logic pcwc,
                                     input logic iord, input logic mr, input logic mw,
                                     input logic irw, input logic m2r, input logic rdst,
                                     input logic rw, input logic asa, input logic [1:0] asb,
                                     input logic [1:0] pcs, input logic zx, input logic hf,
                                     input logic [3:0] al, input logic ill, input logic to);
    return {st, pcw, pcwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, pcs, zx, hf, al, ill, to};
  endfunction

  logic [25:0] e_fetch_rdy, e_fetch_wait, e_decode, e_idle;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [25:0] e;
    mem_ready = 1'b0;
    opCode = 6'b000000;
    func = 6'b100000;
    do_reset();
    n_cmp++;
    if (obs !== e_idle) begin
      n_err++; $display("FAIL reset_idle: got %h want %h", obs, e_idle);
    end
    tick();
    n_cmp++;
    if (obs !== e_fetch_wait) begin
      n_err++; $display("FAIL reset_fetch_wait: got %h want %h", obs, e_fetch_wait);
    end
    tick();
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs !== e_idle) begin
      n_err++; $display("FAIL reset_async_mid_fetch: got %h want %h", obs, e_idle);
    end
    tick();
    reset = 1'b0;
    tick();
    e = e_fetch_wait;
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL reset_fetch_after_release: got %h want %h", obs, e);
    end
  endtask

  task automatic test_rtype();
    logic [25:0] e;
    int pulses = 0;
    opCode = 6'b000000;
    func = 6'b100010;
    mem_ready = 1'b1;
    do_reset();
    tick();
    pulses += int'(IRWrite && PCWrite);
    n_cmp++;
    if (obs !== e_fetch_rdy) begin
      n_err++; $display("FAIL rtype_fetch: got %h want %h", obs, e_fetch_rdy);
    end
    tick();
    pulses += int'(IRWrite || PCWrite);
    n_cmp++;
    if (obs !== e_decode) begin
      n_err++; $display("FAIL rtype_decode: got %h want %h", obs, e_decode);
    end
    tick();
    pulses += int'(IRWrite || PCWrite);
    e = pk(4'd7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 0, 0, 4'b0110, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL rtype_exec_sub: got %h want %h", obs, e);
    end
    tick();
    pulses += int'(IRWrite || PCWrite);
    e = pk(4'd8, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 0, 0, 4'b0110, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL rtype_wb: got %h want %h", obs, e);
    end
    tick();
    n_cmp++;
    if (state !== 4'd1) begin
      n_err++; $display("FAIL rtype_return_fetch: got %0d want 1", state);
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL rtype_irwrite_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_load(input logic [5:0] op, input logic half);
    logic [25:0] e;
    int rd_cycles = 0;
    opCode = op;
    func = 6'b000000;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    e = pk(4'd3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01 << 1, 2'b00, 0, 0, 4'b0010, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL load_mem_addr op=%b: got %h want %h", op, obs, e);
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      rd_cycles += int'(state == 4'd4);
      if (i == 0) begin
        e = pk(4'd4, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, half, 4'b0000, 0, 0);
        n_cmp++;
        if (obs !== e) begin
          n_err++; $display("FAIL load_mem_rd op=%b: got %h want %h", op, obs, e);
        end
      end
    end
    n_cmp++;
    if (rd_cycles !== 4) begin
      n_err++; $display("FAIL load_mem_rd_cycles op=%b: got %0d want 4", op, rd_cycles);
    end
    tick();
    e = pk(4'd5, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 0, half, 4'b0000, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL load_mem_wb op=%b: got %h want %h", op, obs, e);
    end
    tick();
    n_cmp++;
    if (state !== 4'd1) begin
      n_err++; $display("FAIL load_return_fetch op=%b: got %0d want 1", op, state);
    end
  endtask

  task automatic test_store_waits();
    logic [25:0] e;
    opCode = 6'b101011;
    func = 6'b000000;
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) tick();
    mem_ready = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    e = pk(4'd6, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4'b0000, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL store_mem_wr_wait: got %h want %h", obs, e);
    end
    mem_ready = 1'b1;
    tick();
    n_cmp++;
    if ({state, timeout} !== {4'd1, 1'b0}) begin
      n_err++; $display("FAIL store_return_fetch: got %h want %h", {state, timeout}, 5'h02);
    end
  endtask

  task automatic test_timeout();
    logic [25:0] e;
    int fetch_cycles = 0;
    opCode = 6'b000000;
    func = 6'b100000;
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick();
      fetch_cycles += int'(state == 4'd1);
    end
    n_cmp++;
    if (fetch_cycles !== 16) begin
      n_err++; $display("FAIL timeout_fetch_cycles: got %0d want 16", fetch_cycles);
    end
    tick();
    e = pk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4'b0000, 0, 1);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL timeout_trap: got %h want %h", obs, e);
    end
    mem_ready = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL timeout_trap_sticky: got %h want %h", obs, e);
    end
    mem_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    mem_ready = 1'b1;
    #1;
    n_cmp++;
    if (obs !== e_fetch_rdy) begin
      n_err++; $display("FAIL timeout_ready_last_cycle: got %h want %h", obs, e_fetch_rdy);
    end
    tick();
    n_cmp++;
    if (obs !== e_decode) begin
      n_err++; $display("FAIL timeout_no_trap: got %h want %h", obs, e_decode);
    end
  endtask

  task automatic test_branch();
    logic [25:0] e;
    opCode = 6'b000100;
    func = 6'b000000;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    e = pk(4'd9, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 0, 0, 4'b0110, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL branch_state: got %h want %h", obs, e);
    end
    tick();
    n_cmp++;
    if (state !== 4'd1) begin
      n_err++; $display("FAIL branch_return_fetch: got %0d want 1", state);
    end
  endtask

  task automatic test_itype();
    logic [25:0] e;
    opCode = 6'b001101;
    func = 6'b111111;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    e = pk(4'd10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 1, 0, 4'b0001, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL itype_ori_exec: got %h want %h", obs, e);
    end
    tick();
    e = pk(4'd11, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 1, 0, 4'b0001, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL itype_ori_wb: got %h want %h", obs, e);
    end
    tick();
    n_cmp++;
    if (state !== 4'd1) begin
      n_err++; $display("FAIL itype_return_fetch: got %0d want 1", state);
    end
  endtask

  task automatic test_jump();
    logic [25:0] e;
    opCode = 6'b000010;
    func = 6'b000000;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
`ifdef CTRL_JUMP_EN
    e = pk(4'd12, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0, 0, 4'b0000, 0, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL jump_state: got %h want %h", obs, e);
    end
    tick();
    n_cmp++;
    if (state !== 4'd1) begin
      n_err++; $display("FAIL jump_return_fetch: got %0d want 1", state);
    end
`else
    e = pk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4'b0000, 1, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL jump_trap: got %h want %h", obs, e);
    end
    tick();
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL jump_trap_sticky: got %h want %h", obs, e);
    end
`endif
  endtask

  task automatic test_illegal_func();
    logic [25:0] e;
    opCode = 6'b000000;
    func = 6'b111111;
    mem_ready = 1'b1;
    do_reset();
    tick();
    tick();
    tick();
    e = pk(4'd15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 4'b0000, 1, 0);
    n_cmp++;
    if (obs !== e) begin
      n_err++; $display("FAIL illegal_func_trap: got %h want %h", obs, e);
    end
    do_reset();
    n_cmp++;
    if (obs !== e_idle) begin
      n_err++; $display("FAIL illegal_cleared_by_reset: got %h want %h", obs, e_idle);
    end
  endtask

  initial begin
    e_idle       = '0;
    e_fetch_rdy  = pk(4'd1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 4'b0010, 0, 0);
    e_fetch_wait = pk(4'd1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 4'b0010, 0, 0);
    e_decode     = pk(4'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 0, 0, 4'b0010, 0, 0);
    reset = 1'b1;
    opCode = '0;
    func = '0;
    mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_load(6'b100011, 1'b0);
    test_load(6'b100001, 1'b1);
    test_store_waits();
    test_timeout();
    test_branch();
    test_itype();
    test_jump();
    test_illegal_func();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multi-cycle MIPS control FSM. It is the successor to the team's single-cycle combinational decoder.
- It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several clocks. It drives the datapath muxes, register file, IR/PC enables and ALU control.
- It waits on a memory ready handshake with a bounded timeout, and traps on illegal instructions.
- It sits between the IR (which supplies opcode/func) and the shared-memory multi-cycle datapath.

Parameters:
- ALUC_W, 4, aluc output width (≥4); encodings below are zero-extended.
- MEM_WAIT_MAX, 16, max cycles waiting for mem_ready before trap; 0 disables the timeout.
- CNT_W, 5, wait-counter width; must hold MEM_WAIT_MAX.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- opCode  in  6  IR[31:26]; stable from the cycle after IRWrite
- func  in  6  IR[5:0]
- mem_ready  in  1  memory completes the current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load gated externally by ALU zero
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  IR load
- MemtoReg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- RegDest  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register-file write
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = imm, 11 = imm<<2
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- imm_zext  out  1  zero-extend immediate (ANDI/ORI)
- mem_half  out  1  halfword load (LH)
- aluc  out  ALUC_W  AND=0000, OR=0001, ADD=0010, SUB=0110, SLT=0111, SLL=1000, SRL=1001
- illegal  out  1  sticky trap flag
- timeout  out  1  sticky memory-timeout flag
- state  out  4  current state, for debug

Behaviour:

Structure and reset:
- State register and wait counter are the only flops. Outputs are combinational from state, opCode/func and mem_ready.
- Reset sets state = IDLE (0) and counter = 0.
- In IDLE every output is 0, including aluc, illegal and timeout. IDLE goes to FETCH unconditionally.
- Reset asserted in any state, including mid-wait, returns to IDLE immediately. No memory strobe may remain asserted.
- Any output not listed for a state is 0.

States (encoding in brackets) and transitions:
- FETCH(1): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, aluc=ADD. IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; that cycle goes to DECODE. Otherwise hold.
- DECODE(2): ALUSrcA=0, ALUSrcB=11, aluc=ADD. Next state by opcode:
  - 000000 with func in {100000 ADD, 100010 SUB, 000000 SLL, 000010 SRL, 100100 AND, 100101 OR, 101010 SLT} -> R_EXEC.
  - 100011 LW, 100001 LH, 101011 SW -> MEM_ADDR.
  - 000100 BEQ -> BRANCH.
  - 001000 ADDI, 001100 ANDI, 001101 ORI -> I_EXEC.
  - All else -> TRAP.
- MEM_ADDR(3): ALUSrcA=1, ALUSrcB=10, aluc=ADD. SW -> MEM_WR, else MEM_RD.
- MEM_RD(4): MemRead=1, IorD=1, mem_half=(opCode==100001). Goes to MEM_WB on mem_ready.
- MEM_WB(5): RegWrite=1, MemtoReg=1, RegDest=0, mem_half as in MEM_RD. Goes to FETCH.
- MEM_WR(6): MemWrite=1, IorD=1. Goes to FETCH on mem_ready.
- R_EXEC(7): ALUSrcA=1, ALUSrcB=00, aluc decoded from func. Goes to R_WB.
- R_WB(8): RegDest=1, RegWrite=1, MemtoReg=0, aluc held. Goes to FETCH.
- BRANCH(9): ALUSrcA=1, ALUSrcB=00, aluc=SUB, PCWriteCond=1, PCSource=01. Goes to FETCH.
- I_EXEC(10): ALUSrcA=1, ALUSrcB=10, aluc = ADD/AND/OR per opcode, imm_zext=1 for ANDI/ORI. Goes to I_WB.
- I_WB(11): RegDest=0, RegWrite=1, MemtoReg=0, aluc and imm_zext held. Goes to FETCH.
- JUMP(12): only with the optional feature (see below).
- TRAP(15): all datapath outputs 0. illegal=1 for a decode trap, timeout=1 for a wait trap. Stays until reset.

Wait counter:
- Counter clears on entry to FETCH, MEM_RD or MEM_WR. It increments each cycle the FSM is in one of those states with mem_ready=0.
- If MEM_WAIT_MAX≠0 and counter==MEM_WAIT_MAX-1 with mem_ready=0, next state = TRAP with timeout set.
- mem_ready=1 in that same cycle wins: normal transition, no trap.

Latency with mem_ready always 1:
- R-type / I-type: 4 cycles.
- LW / LH: 5 cycles.
- SW: 4 cycles.
- BEQ: 3 cycles.

Optional Feature:
- Macro: CTRL_JUMP_EN.
- Defined: opcode 000010 in DECODE goes to JUMP(12). JUMP drives PCWrite=1, PCSource=10, then goes to FETCH; 3 cycles total.
- Undefined: opcode 000010 goes to TRAP with illegal=1. State 12 is unreachable.

Test Plan:
- Reset mid-FETCH with MemRead=1, mem_ready=0 -> next sample shows state=0, all outputs 0. FETCH follows 1 cycle after reset deassert.
- opCode=000000, func=100010 (SUB), mem_ready=1 -> states 1,2,7,8,1. R_EXEC aluc=0110. R_WB RegDest=1, RegWrite=1. IRWrite/PCWrite pulse exactly once.
- opCode=100011 (LW), mem_ready low 3 cycles in MEM_RD -> MEM_RD held 4 cycles, MEM_WB asserts MemtoReg=1, RegWrite=1, mem_half=0. Repeat with 100001 -> mem_half=1.
- MEM_WAIT_MAX=16, mem_ready held 0 in FETCH -> TRAP after 16 FETCH cycles, timeout=1, MemRead=0. Rerun with mem_ready=1 on the 16th cycle -> no trap.
- opCode=000100 (BEQ) -> BRANCH: PCWriteCond=1, PCSource=01, aluc=0110. Returns to FETCH in 3 total cycles.
- opCode=000010 -> with CTRL_JUMP_EN: PCWrite=1, PCSource=10, back to FETCH. Without it: state=15, illegal=1 held until reset. Also opCode=000000, func=111111 -> TRAP in both builds.
